prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter DEPTH, 4, number of instruction entries buffered (power of two, 2..16).
REQ-002 Parameter RESET_PC, 16'h0000, first program address fetched after reset.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port resetN  input  1  asynchronous, active-low reset.
REQ-005 Port program_address  output  16  fetch address driven to the RAM instruction port.
REQ-006 Port fetch_req  output  1  high when program_address is a valid fetch this cycle.
REQ-007 Port data_b  input  8  RAM instruction data, valid exactly one cycle after fetch_req.
REQ-008 Port jump  input  1  redirect request from the processor.
REQ-009 Port jump_address  input  16  redirect target, sampled when jump=1.
REQ-010 Port next_instruction  output  8  oldest buffered instruction (head of queue).
REQ-011 Port instr_valid  output  1  head entry present.
REQ-012 Port instr_ready  input  1  consumer (instruction register stage) accepts head this cycle.
REQ-013 Port level  output  $clog2(DEPTH)+1  number of entries currently stored.

Function
REQ-014 Queue SHALL be a circular FIFO of DEPTH x 8 with wrapping read/write pointers; level = writes - reads.
REQ-015 FSM states SHALL be RUN, STALL, REDIRECT.
REQ-016 RUN: fetch_req=1 when level + inflight < DEPTH; otherwise go to STALL with fetch_req=0.
REQ-017 STALL: fetch_req=0; return to RUN in the cycle after level + inflight < DEPTH becomes true.
REQ-018 Any state, jump=1: next state REDIRECT; fetch_req=0 in the jump cycle.
REQ-019 REDIRECT (one cycle): program_address = captured jump_address, fetch_req=1, then RUN.
REQ-020 Each accepted fetch (fetch_req=1) SHALL increment program_address by 1 (mod 2^16, FFFF wraps to 0000) on the following edge.
REQ-021 inflight SHALL be a 1-bit flag set on the edge after fetch_req=1; data_b is written to the queue in the cycle inflight=1.
REQ-022 Pop SHALL occur when instr_valid && instr_ready && !jump; next_instruction SHALL advance one edge later.
REQ-023 Simultaneous push and pop SHALL leave level unchanged; pop when empty SHALL be ignored.
REQ-024 Push is never blocked: the fetch credit rule (REQ-016) guarantees room, so overflow cannot occur.
REQ-025 jump=1 SHALL, on the same edge, empty the queue (level=0, pointers equal), clear inflight, and discard any data_b returning in that cycle.
REQ-026 jump=1 and instr_ready=1 in the same cycle: the jump wins and no pop is counted.
REQ-027 jump=1 during REDIRECT SHALL restart REDIRECT with the newer jump_address.
REQ-028 instr_valid SHALL equal (level != 0); next_instruction SHALL be 8'h00 when empty.
REQ-029 Fetch-to-instr_valid latency SHALL be 2 cycles: fetch in cycle N, data_b in N+1, instr_valid in N+2.

Reset
REQ-030 resetN=0 SHALL immediately force: state RUN, program_address=RESET_PC, level=0, inflight=0, instr_valid=0, next_instruction=8'h00, fetch_req=0.
REQ-031 fetch_req SHALL stay 0 until the first rising clock edge after resetN deasserts; that edge starts fetching at RESET_PC.
REQ-032 Reset asserted mid-operation SHALL discard queue contents and any in-flight data without a partial push.

Verification
REQ-033 Reset release, RAM returns addr[7:0], instr_ready=0 -> fetches 0000..0003, level=4, STALL, fetch_req=0, next_instruction=8'h00.
REQ-034 Full queue, then instr_ready=1 held -> one instruction per cycle in order 00,01,02,...; level stays constant after one refill cycle; no gaps.
REQ-035 jump=1, jump_address=16'h1234 with level=3 and inflight=1 -> level=0 next edge, stale data dropped, next fetch at 1234, first instr_valid 3 cycles after jump.
REQ-036 program_address=16'hFFFE, continuous fetch -> addresses FFFE, FFFF, 0000, 0001.
REQ-037 Back-to-back jump to 0100 then 0200 -> only 0200 fetched, no entry from 0100 ever appears.
REQ-038 resetN pulsed low for 1 cycle with level=2 -> outputs at reset values asynchronously, refetch from 0000 afterwards.

Source files
------------

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch FIFO with credit-based fetch and jump redirect.
// Ports: clock/resetN, program_address/fetch_req/data_b (RAM), jump/jump_address,
//   next_instruction/instr_valid/instr_ready (consumer), level (occupancy).
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clock,
  input  logic                     resetN,
  output logic [15:0]              program_address,
  output logic                     fetch_req,
  input  logic [7:0]               data_b,
  input  logic                     jump,
  input  logic [15:0]              jump_address,
  output logic [7:0]               next_instruction,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    REDIRECT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            started;
  logic            inflight;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic            credit;
  logic            push;
  logic            pop;

  // A returning byte always needs a slot, so it
  // counts against capacity while in flight.
  assign credit = ((LW+1)'(level) + (LW+1)'(inflight))
                  < (LW+1)'(DEPTH);

  assign push = inflight && !jump;
  assign pop  = instr_valid && instr_ready && !jump;

  assign instr_valid      = (level != '0);
  assign next_instruction = instr_valid ? mem[rd_ptr] : 8'h00;

  always_comb begin
    state_nxt = state;
    fetch_req = 1'b0;
    if (jump) begin
      state_nxt = REDIRECT;
    end else begin
      unique case (state)
        RUN: begin
          // Hold off the very first fetch until one
          // edge after reset release.
          if (started) begin
            if (credit) fetch_req = 1'b1;
            else        state_nxt = STALL;
          end
        end
        STALL: begin
          if (credit) state_nxt = RUN;
        end
        REDIRECT: begin
          fetch_req = 1'b1;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state   <= RUN;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      program_address <= RESET_PC;
      inflight        <= 1'b0;
    end else if (jump) begin
      program_address <= jump_address;
      inflight        <= 1'b0;
    end else begin
      inflight <= fetch_req;
      if (fetch_req)
        program_address <= program_address + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (jump) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; instr_valid masks
  // stale entries.
  always_ff @(posedge clock) begin
    if (push && resetN)
      mem[wr_ptr] <= data_b;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: random + directed stimulus against a queue-based
// reference model of the prefetch queue.
module tb_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clock;
  logic        resetN;
  logic [15:0] program_address;
  logic        fetch_req;
  logic [7:0]  data_b;
  logic        jump;
  logic [15:0] jump_address;
  logic [7:0]  next_instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  level;

  prefetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .program_address(program_address),
    .fetch_req(fetch_req),
    .data_b(data_b),
    .jump(jump),
    .jump_address(jump_address),
    .next_instruction(next_instruction),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .level(level)
  );

  int n_cmp;
  int n_bad;

  byte unsigned m_q[$];
  bit           m_infl;
  logic [15:0]  m_infl_addr;
  logic [15:0]  m_pc;
  int           m_mode;
  bit           m_started;

  logic         ram_fetch;
  logic [15:0]  ram_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ram_rd(logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_infl      = 1'b0;
    m_infl_addr = '0;
    m_pc        = RST_PC;
    m_mode      = 0;
    m_started   = 1'b0;
    ram_fetch   = 1'b0;
    ram_addr    = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_fetch", fetch_req, 0);
    chk("rst_pc", program_address, RST_PC);
    chk("rst_level", level, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", next_instruction, 0);
  endtask

  task automatic do_reset(int hold);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    repeat (hold) @(posedge clock);
    @(negedge clock);
    resetN      = 1'b1;
    jump        = 1'b0;
    instr_ready = 1'b0;
    data_b      = 8'($urandom);
    #1;
    chk("rel_fetch", fetch_req, 0);
    chk("rel_pc", program_address, RST_PC);
    // The next edge arms fetching.
    m_started = 1'b1;
  endtask

  task automatic cycle(bit j, logic [15:0] ja, bit rdy);
    bit credit;
    bit exp_fetch;
    @(negedge clock);
    jump         = j;
    jump_address = ja;
    instr_ready  = rdy;
    data_b       = ram_fetch ? ram_rd(ram_addr)
                             : 8'($urandom);
    #1;
    credit    = (m_q.size() + int'(m_infl)) < DEPTH;
    exp_fetch = 1'b0;
    if (!j) begin
      case (m_mode)
        0:       exp_fetch = m_started && credit;
        2:       exp_fetch = 1'b1;
        default: exp_fetch = 1'b0;
      endcase
    end
    chk("fetch_req", fetch_req, exp_fetch);
    chk("pc", program_address, m_pc);
    chk("level", level, m_q.size());
    chk("valid", instr_valid, m_q.size() != 0);
    chk("instr", next_instruction,
        m_q.size() != 0 ? m_q[0] : 8'h00);
    ram_fetch = fetch_req;
    ram_addr  = program_address;
    if (j) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = ja;
      m_mode = 2;
    end else begin
      if (rdy && m_q.size() != 0)
        void'(m_q.pop_front());
      if (m_infl)
        m_q.push_back(ram_rd(m_infl_addr));
      m_infl      = exp_fetch;
      m_infl_addr = m_pc;
      if (exp_fetch) m_pc = m_pc + 16'd1;
      case (m_mode)
        0: if (m_started && !credit) m_mode = 1;
        1: if (credit) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
    m_started = 1'b1;
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    resetN       = 1'b0;
    jump         = 1'b0;
    jump_address = '0;
    instr_ready  = 1'b0;
    data_b       = '0;
    model_reset();
    #1;
    chk_reset_outputs();
    do_reset(2);

    // Fill with no consumer: 4 fetches then stall.
    repeat (8) cycle(1'b0, 16'h0, 1'b0);
    // Drain continuously.
    repeat (12) cycle(1'b0, 16'h0, 1'b1);

    // Jump with level=3 and one byte in flight.
    do_reset(1);
    repeat (4) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h1234, 1'b1);
    repeat (6) cycle(1'b0, 16'h0, 1'b1);

    // Address wrap.
    cycle(1'b1, 16'hFFFE, 1'b0);
    repeat (6) cycle(1'b0, 16'h0, 1'b1);

    // Back-to-back jumps.
    cycle(1'b1, 16'h0100, 1'b0);
    cycle(1'b1, 16'h0200, 1'b1);
    repeat (6) cycle(1'b0, 16'h0, 1'b1);

    // One-cycle reset pulse with level=2.
    do_reset(1);
    repeat (3) cycle(1'b0, 16'h0, 1'b0);
    do_reset(1);
    repeat (6) cycle(1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      bit          j;
      bit          rdy;
      logic [15:0] ja;
      j   = ($urandom % 12) == 0;
      ja  = ($urandom % 4 == 0) ? 16'hFFFE
                                : 16'($urandom);
      rdy = (i / 200) % 2 == 0 ? ($urandom % 4 != 0)
                               : ($urandom % 4 == 0);
      if ($urandom % 250 == 0)
        do_reset(int'($urandom % 2) + 1);
      cycle(j, ja, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
